// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - UART-fed instruction memory loader and pipeline step sequencer
// Packs program bytes big-endian into words, writes them through a registered strobe, then gates o_step.
module instr_mem_loader #(
    parameter int                      SIZE_ADDR_PC = 32,
    parameter int                      TOTAL_SIZE   = 256,
    parameter logic [SIZE_ADDR_PC-1:0] HALT_WORD    = {SIZE_ADDR_PC{1'b1}},
    parameter logic [7:0]              CMD_LOAD     = 8'h4C,
    parameter logic [7:0]              CMD_RUN      = 8'h52,
    parameter logic [7:0]              CMD_STEP     = 8'h53
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    input  logic                    i_halt,
    output logic [SIZE_ADDR_PC-1:0] o_instruction_address,
    output logic [SIZE_ADDR_PC-1:0] o_instruction,
    output logic                    o_flag_write_intruc,
    output logic                    o_step,
    output logic                    o_load_done,
    output logic                    o_halted,
    output logic                    o_error
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WR_PULSE = 2'd2,
        RUN      = 2'd3
    } state_t;

    localparam logic [SIZE_ADDR_PC-1:0] LAST_ADDR = SIZE_ADDR_PC'(TOTAL_SIZE - 1);

    state_t                  state;
    logic [1:0]              byte_cnt;
    logic [SIZE_ADDR_PC-1:0] asm_reg;
    logic [SIZE_ADDR_PC-1:0] next_addr;
    logic [SIZE_ADDR_PC-1:0] asm_next;
    logic                    cmd_ok;

    assign asm_next = {asm_reg[SIZE_ADDR_PC-9:0], i_rx_data};
    assign cmd_ok   = o_load_done & ~o_halted;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                 <= IDLE;
            byte_cnt              <= 2'd0;
            asm_reg               <= '0;
            next_addr             <= '0;
            o_instruction_address <= '0;
            o_instruction         <= '0;
            o_flag_write_intruc   <= 1'b0;
            o_step                <= 1'b0;
            o_load_done           <= 1'b0;
            o_halted              <= 1'b0;
            o_error               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_step <= 1'b0;
                    if (o_load_done && i_halt) begin
                        o_halted <= 1'b1;
                    end
                    if (i_rx_valid) begin
                        // A load command overrides a halt sampled in the same cycle.
                        if (i_rx_data == CMD_LOAD) begin
                            o_load_done <= 1'b0;
                            o_halted    <= 1'b0;
                            o_error     <= 1'b0;
                            next_addr   <= '0;
                            byte_cnt    <= 2'd0;
                            state       <= LOAD;
                        end else if ((i_rx_data == CMD_RUN) && cmd_ok) begin
                            o_step <= 1'b1;
                            state  <= RUN;
                        end else if ((i_rx_data == CMD_STEP) && cmd_ok) begin
                            o_step <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (i_rx_valid) begin
                        asm_reg  <= asm_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_instruction         <= asm_next;
                            o_instruction_address <= next_addr;
                            state                 <= WR_PULSE;
                        end
                    end
                end

                WR_PULSE: begin
                    // Bytes of the following word keep assembling while the strobe runs.
                    if (i_rx_valid) begin
                        asm_reg  <= asm_next;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    // First cycle lets address/data settle; the strobe register doubles as phase.
                    if (!o_flag_write_intruc) begin
                        o_flag_write_intruc <= 1'b1;
                    end else begin
                        o_flag_write_intruc <= 1'b0;
                        if (o_instruction == HALT_WORD) begin
                            o_load_done <= 1'b1;
                            state       <= IDLE;
                        end else if (o_instruction_address == LAST_ADDR) begin
                            o_error <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            next_addr <= next_addr + 1'b1;
                            state     <= LOAD;
                        end
                    end
                end

                RUN: begin
                    if (i_halt) begin
                        o_step   <= 1'b0;
                        o_halted <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        o_step <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        wr_strobe;
    logic        step;
    logic        load_done;
    logic        halted;
    logic        error;

    int n_tests;
    int n_fail;
    int step_cnt;
    int wr_cnt;

    logic [63:0] exp_q[$];
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic        prev_strobe;

    instr_mem_loader #(
        .SIZE_ADDR_PC(32),
        .TOTAL_SIZE  (4)
    ) dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_rx_data            (rx_data),
        .i_rx_valid           (rx_valid),
        .i_halt               (halt),
        .o_instruction_address(instr_addr),
        .o_instruction        (instr),
        .o_flag_write_intruc  (wr_strobe),
        .o_step               (step),
        .o_load_done          (load_done),
        .o_halted             (halted),
        .o_error              (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: pops the scoreboard on every strobe rising edge.
    always @(negedge clk) begin
        if (step) step_cnt++;
        if (wr_strobe && !prev_strobe) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 1, 0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", {32'd0, instr_addr}, {32'd0, e[63:32]});
                check_eq("wr_data", {32'd0, instr}, {32'd0, e[31:0]});
                check_eq("addr_setup", {32'd0, prev_addr}, {32'd0, instr_addr});
                check_eq("data_setup", {32'd0, prev_data}, {32'd0, instr});
            end
        end
        if (wr_strobe && prev_strobe) check_eq("strobe_width", 2, 1);
        prev_addr   = instr_addr;
        prev_data   = instr;
        prev_strobe = wr_strobe;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !load_done && !error; i++) tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"}, {32'd0, instr_addr}, 0);
        check_eq({tag, "_data"}, {32'd0, instr}, 0);
        check_eq({tag, "_strobe"}, {63'd0, wr_strobe}, 0);
        check_eq({tag, "_step"}, {63'd0, step}, 0);
        check_eq({tag, "_done"}, {63'd0, load_done}, 0);
        check_eq({tag, "_halted"}, {63'd0, halted}, 0);
        check_eq({tag, "_error"}, {63'd0, error}, 0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        step_cnt    = 0;
        wr_cnt      = 0;
        prev_addr   = '0;
        prev_data   = '0;
        prev_strobe = 1'b0;
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        halt        = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Commands before any load are ignored
        step_cnt = 0;
        send_byte(8'h52);
        send_byte(8'h53);
        send_byte(8'h41);
        tick(3);
        check_eq("preload_steps", step_cnt, 0);
        check_eq("preload_done", {63'd0, load_done}, 0);

        // Two-word program
        exp_q.push_back({32'd0, 32'h12345678});
        exp_q.push_back({32'd1, 32'hFFFFFFFF});
        wr_cnt = 0;
        send_byte(8'h4C);
        send_word(32'h12345678);
        send_word(32'hFFFFFFFF);
        wait_done(20);
        check_eq("load2_done", {63'd0, load_done}, 1);
        check_eq("load2_error", {63'd0, error}, 0);
        check_eq("load2_writes", wr_cnt, 2);
        check_eq("load2_queue", exp_q.size(), 0);

        // Single steps
        step_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h53);
            check_eq("step_pulse", {63'd0, step}, 1);
            tick(1);
            check_eq("step_single", {63'd0, step}, 0);
            tick(1);
        end
        check_eq("step_count", step_cnt, 3);
        halt = 1'b1;
        tick(2);
        check_eq("step_halted", {63'd0, halted}, 1);
        send_byte(8'h53);
        tick(2);
        check_eq("step_after_halt", step_cnt, 3);
        halt = 1'b0;

        // Continuous run
        exp_q.push_back({32'd0, 32'hA5A50001});
        exp_q.push_back({32'd1, 32'hFFFFFFFF});
        send_byte(8'h4C);
        check_eq("load_clears_halt", {63'd0, halted}, 0);
        send_word(32'hA5A50001);
        send_word(32'hFFFFFFFF);
        wait_done(20);
        check_eq("run_load_done", {63'd0, load_done}, 1);
        step_cnt = 0;
        send_byte(8'h52);
        check_eq("run_step_on", {63'd0, step}, 1);
        tick(19);
        check_eq("run_step_held", {63'd0, step}, 1);
        halt = 1'b1;
        tick(1);
        check_eq("run_step_off", {63'd0, step}, 0);
        check_eq("run_halted", {63'd0, halted}, 1);
        check_eq("run_step_cycles", step_cnt, 20);
        halt = 1'b0;
        send_byte(8'h52);
        tick(2);
        check_eq("run_after_halt", step_cnt, 20);

        // Overflow with TOTAL_SIZE = 4
        for (int a = 0; a < 4; a++) exp_q.push_back({32'(a), 32'hC0DE0000 + 32'(a)});
        wr_cnt = 0;
        send_byte(8'h4C);
        for (int a = 0; a < 4; a++) send_word(32'hC0DE0000 + 32'(a));
        wait_done(40);
        check_eq("ovf_error", {63'd0, error}, 1);
        check_eq("ovf_done", {63'd0, load_done}, 0);
        check_eq("ovf_writes", wr_cnt, 4);
        check_eq("ovf_queue", exp_q.size(), 0);
        send_byte(8'h4C);
        check_eq("ovf_cleared", {63'd0, error}, 0);

        // Reset in the middle of a word
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        tick(1);
        check_all_zero("midrst");
        rst = 1'b0;
        tick(1);
        exp_q.push_back({32'd0, 32'h11223344});
        wr_cnt = 0;
        send_byte(8'h4C);
        send_word(32'h11223344);
        tick(6);
        check_eq("midrst_writes", wr_cnt, 1);
        check_eq("midrst_queue", exp_q.size(), 0);
        check_eq("midrst_done", {63'd0, load_done}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Control sequencer that owns the write port and the step enable of the instruction memory. It takes byte commands and program bytes from the debug UART receiver and packs program bytes into 32-bit words. Each word goes to consecutive instruction-memory addresses through a glitch-safe write pulse. Once a program is loaded, it schedules execution by driving the memory/pipeline step enable, either continuously (run) or one cycle per command (step), until the pipeline reports HALT.

## Interface
- `SIZE_ADDR_PC`, default 32: width of the address and instruction words.
- `TOTAL_SIZE`, default 256: instruction memory depth in words.
- `HALT_WORD`, default 32'hFFFFFFFF: instruction word that terminates a load.
- `CMD_LOAD` / `CMD_RUN` / `CMD_STEP`, defaults 8'h4C / 8'h52 / 8'h53: command byte codes.
- `i_clk`  in  1  single clock; all logic updates on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  byte from the UART receiver.
- `i_rx_valid`  in  1  one-cycle pulse; `i_rx_data` is valid in that cycle.
- `i_halt`  in  1  pipeline reports that HALT has retired; level, sampled each cycle.
- `o_instruction_address`  out  SIZE_ADDR_PC  word address for the memory write port.
- `o_instruction`  out  SIZE_ADDR_PC  word to write.
- `o_flag_write_intruc`  out  1  write strobe; the memory writes on its rising edge.
- `o_step`  out  1  enables one fetch/pipeline advance per cycle high.
- `o_load_done`  out  1  a program terminated by HALT_WORD is resident.
- `o_halted`  out  1  the pipeline reached HALT since the last load.
- `o_error`  out  1  the load overflowed TOTAL_SIZE without a HALT_WORD.

## Operation
- **States:** IDLE, LOAD, WR_PULSE, RUN.
- **Reset:** state = IDLE. All outputs = 0. The byte counter and the assembly register = 0.
- **IDLE:**
  - Command bytes are taken only on `i_rx_valid`. Unknown codes are ignored.
  - CMD_LOAD: clears `o_load_done`, `o_halted` and `o_error`; next address = 0; byte counter = 0; go to LOAD. It is accepted in any IDLE condition.
  - CMD_RUN: accepted only if `o_load_done`=1 and `o_halted`=0; go to RUN.
  - CMD_STEP: accepted under the same condition as CMD_RUN. It drives `o_step`=1 for exactly the next cycle and stays in IDLE.
- **LOAD (byte assembly):**
  - Each valid byte shifts into a 32-bit assembly register, big-endian: the first byte becomes bits [31:24].
  - A 2-bit counter wraps after the 4th byte.
  - In LOAD, every received byte is program data; command codes are not decoded.
  - On the 4th byte:
    - `o_instruction` <= assembled word.
    - `o_instruction_address` <= next address.
    - Go to WR_PULSE.
  - Address and data therefore settle one full cycle before the strobe rises.
- **WR_PULSE:**
  - `o_flag_write_intruc`=1 for exactly one cycle, while address and data are held.
  - On leaving WR_PULSE the strobe returns to 0.
  - Leaving WR_PULSE, if the word == HALT_WORD: `o_load_done`=1, go to IDLE.
  - Leaving WR_PULSE, else if the address == TOTAL_SIZE-1: `o_error`=1, go to IDLE.
  - Leaving WR_PULSE, otherwise: next address += 1, go to LOAD.
  - A byte arriving during WR_PULSE is still accepted into the assembly register and counter; no byte is dropped.
- **RUN:**
  - `o_step`=1 every cycle while `i_halt`=0.
  - When `i_halt`=1 is sampled: `o_step`=0 in the following cycle, `o_halted`=1, go to IDLE.
  - Received bytes are ignored in RUN.
- **Step mode:** if `i_halt`=1 is sampled in IDLE while `o_load_done`=1, set `o_halted`=1. Further CMD_STEP and CMD_RUN are ignored until the next CMD_LOAD.
- **Address/data hold:** `o_instruction_address` and `o_instruction` hold their last values outside write sequences.

## Timing
- **Write latency:** 4th byte `i_rx_valid` in cycle N → address/data valid in N+1 → strobe high in N+2 only → strobe low in N+3.
- **Minimum byte spacing:** 1 cycle. Back-to-back bytes are legal, including during WR_PULSE.
- **CMD_STEP:** valid in cycle N → `o_step`=1 in N+1 only.
- **CMD_RUN:** valid in cycle N → `o_step`=1 from N+1 onward.
- **Run stop:** `i_halt` seen in cycle M → `o_step`=0 from M+1 and `o_halted`=1 from M+1.
- **Synchronous reset:** wins over everything, including mid-load and mid-pulse. A reset during WR_PULSE drops the strobe in the next cycle.
- **Strobe glitches:** `o_flag_write_intruc` never toggles within a cycle, and never rises in the same cycle that address/data change.

## Test plan
- **Load a 2-word program:** reset, then send 4C, 12 34 56 78, FF FF FF FF.
  - Two strobes occur: addr 0 = 0x12345678, then addr 1 = 0xFFFFFFFF.
  - `o_load_done`=1 and `o_error`=0.
  - On each strobe, address/data are stable one cycle before the rising edge.
- **Step:** after the load, send 53 three times → exactly three single-cycle `o_step` pulses, each one cycle after its byte. Then raise `i_halt`, send 53 → no pulse, `o_halted`=1.
- **Run:** load, send 52 → `o_step` held high. Assert `i_halt` 20 cycles later → `o_step` falls the next cycle, `o_halted`=1, state IDLE.
- **Commands before load:** send 52 and 53 with `o_load_done`=0 → `o_step` stays 0. Send 41 → ignored.
- **Overflow:** TOTAL_SIZE=4, load 4 non-HALT words → 4 strobes at addresses 0–3, then `o_error`=1, `o_load_done`=0. A new 4C clears `o_error`.
- **Reset mid-load:** assert `i_reset` after 2 bytes of a word → all outputs 0. A following 4C plus a 4-byte word writes addr 0, and the partial bytes are not used.
